// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA SDRAM read-port responder.
package vga_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DATA} vga_rsp_state_t;

    localparam int unsigned VGA_BURST_WORDS = 4;

    // Clears the byte offset within one burst of 32-bit words.
    function automatic logic [31:0] vga_burst_align(
        input logic [31:0] addr,
        input int unsigned words
    );
        logic [31:0] mask;
        mask = (words << 2) - 32'd1;
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/vga_req_queue.sv
// Two-deep address FIFO holding accepted VGA burst requests.
module vga_req_queue #(
    parameter int unsigned W = 26
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] e0_q, e0_d;
    logic [W-1:0] e1_q, e1_d;
    logic [1:0]   cnt_q, cnt_d;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = din;
                else               e1_d = din;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                // New entry lands behind whatever survives the pop.
                if (cnt_q == 2'd1) begin
                    e0_d = din;
                end else begin
                    e0_d = e1_q;
                    e1_d = din;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign head  = e0_q;

endmodule

// File: rtl/vga_sdram_responder.sv
// Queues VGA burst reads, issues them to the SDRAM controller when granted,
// and returns the read beats with a last-beat complete marker.
module vga_sdram_responder
    import vga_pkg::*;
#(
    parameter int unsigned BURST_WORDS = VGA_BURST_WORDS,
    parameter int unsigned ADDR_W      = 26
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vga_sdram_req,
    input  logic [ADDR_W-1:0] vga_sdram_addr,
    output logic              vga_sdram_ack,
    output logic [31:0]       vga_sdram_rdata,
    output logic              vga_sdram_rdvalid,
    output logic              vga_sdram_complete,
    input  logic              arb_grant,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rdvalid,
    output logic              vga_busy,
    output logic              err_unexpected
);

    localparam int unsigned BEAT_W = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_WORDS - 1);

    vga_rsp_state_t    state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              ack_q, ack_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rdvalid_q, rdvalid_d;
    logic              complete_q, complete_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              push;
    logic              pop;
    logic [1:0]        q_count;
    logic [ADDR_W-1:0] q_head;

    // The !ack_q term keeps a request that is still held high from being taken twice.
    assign push = vga_sdram_req && !ack_q && (q_count < 2'd2);

    vga_req_queue #(.W(ADDR_W)) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (vga_sdram_addr),
        .count   (q_count),
        .head    (q_head)
    );

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        ack_d      = push;
        rdata_d    = rdata_q;
        rdvalid_d  = 1'b0;
        complete_d = 1'b0;
        pop        = 1'b0;
        busy_d     = (q_count != 2'd0) || (state_q != IDLE);
        err_d      = err_q || (mem_rdvalid && (state_q != DATA));
        unique case (state_q)
            IDLE: begin
                if (q_count != 2'd0) state_d = ISSUE;
            end
            ISSUE: begin
                if (mem_req && mem_ack) begin
                    state_d = DATA;
                    beat_d  = '0;
                end
            end
            DATA: begin
                if (mem_rdvalid) begin
                    rdata_d   = mem_rdata;
                    rdvalid_d = 1'b1;
                    beat_d    = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        complete_d = 1'b1;
                        pop        = 1'b1;
                        state_d    = ((q_count == 2'd2) || push) ? ISSUE : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            ack_q      <= 1'b0;
            rdata_q    <= 32'd0;
            rdvalid_q  <= 1'b0;
            complete_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            rdvalid_q  <= rdvalid_d;
            complete_q <= complete_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign mem_req            = (state_q == ISSUE) && arb_grant;
    assign mem_addr           = ADDR_W'(vga_burst_align(32'(q_head), BURST_WORDS));
    assign vga_sdram_ack      = ack_q;
    assign vga_sdram_rdata    = rdata_q;
    assign vga_sdram_rdvalid  = rdvalid_q;
    assign vga_sdram_complete = complete_q;
    assign vga_busy           = busy_q;
    assign err_unexpected     = err_q;

endmodule

// File: tb/tb_vga_sdram_responder.sv
// Self-checking bench: directed burst table, multi-cycle corner cases and a
// randomized run against a queue-based requester/controller model.
module tb_vga_sdram_responder;

    localparam int BW = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vga_sdram_req = 1'b0;
    logic [25:0] vga_sdram_addr = '0;
    logic        vga_sdram_ack;
    logic [31:0] vga_sdram_rdata;
    logic        vga_sdram_rdvalid;
    logic        vga_sdram_complete;
    logic        arb_grant = 1'b0;
    logic        mem_req;
    logic [25:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_rdvalid = 1'b0;
    logic        vga_busy;
    logic        err_unexpected;

    always #5 clk = ~clk;

    vga_sdram_responder dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .vga_sdram_req      (vga_sdram_req),
        .vga_sdram_addr     (vga_sdram_addr),
        .vga_sdram_ack      (vga_sdram_ack),
        .vga_sdram_rdata    (vga_sdram_rdata),
        .vga_sdram_rdvalid  (vga_sdram_rdvalid),
        .vga_sdram_complete (vga_sdram_complete),
        .arb_grant          (arb_grant),
        .mem_req            (mem_req),
        .mem_addr           (mem_addr),
        .mem_ack            (mem_ack),
        .mem_rdata          (mem_rdata),
        .mem_rdvalid        (mem_rdvalid),
        .vga_busy           (vga_busy),
        .err_unexpected     (err_unexpected)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [25:0] align(input logic [25:0] a);
        return a - (a % 26'(BW * 4));
    endfunction

    function automatic logic [31:0] dword(input logic [25:0] a, input int b);
        return {a, 6'(b)};
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_ack"}, vga_sdram_ack, 0);
        chk({tag, "_rdata"}, vga_sdram_rdata, 0);
        chk({tag, "_rdvalid"}, vga_sdram_rdvalid, 0);
        chk({tag, "_complete"}, vga_sdram_complete, 0);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_busy"}, vga_busy, 0);
        chk({tag, "_err"}, err_unexpected, 0);
    endtask

    // Post one request, see it acked, issued and accepted by the controller.
    task automatic req_issue(input logic [25:0] a, input logic [25:0] ea);
        vga_sdram_req = 1'b1;
        vga_sdram_addr = a;
        arb_grant = 1'b1;
        @(negedge clk);
        chk("ack_not_early", vga_sdram_ack, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ack", vga_sdram_ack, 1);
        @(posedge clk); #1;
        vga_sdram_req = 1'b0;
        @(negedge clk);
        chk("ack_pulse", vga_sdram_ack, 0);
        chk("mem_req", mem_req, 1);
        chk("mem_addr", mem_addr, 32'(ea));
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
    endtask

    task automatic beats(input logic [31:0] base, input int gap, input int n);
        for (int i = 0; i < n; i++) begin
            mem_rdvalid = 1'b1;
            mem_rdata = base + 32'(i);
            @(posedge clk); #1;
            mem_rdvalid = 1'b0;
            mem_rdata = '0;
            @(negedge clk);
            chk("beat_valid", vga_sdram_rdvalid, 1);
            chk("beat_data", vga_sdram_rdata, base + 32'(i));
            chk("beat_complete", vga_sdram_complete, 32'(i == BW - 1));
            if (i == BW - 1) chk("busy_at_complete", vga_busy, 1);
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                    chk("gap_quiet", {vga_sdram_rdvalid, vga_sdram_complete}, 0);
                end
            end
        end
    endtask

    task automatic finish_burst();
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_after", vga_busy, 0);
        chk("quiet_after", {vga_sdram_rdvalid, vga_sdram_complete}, 0);
        @(posedge clk); #1;
    endtask

    task automatic single_burst(input logic [25:0] a, input logic [25:0] ea,
                                input logic [31:0] base, input int gap);
        req_issue(a, ea);
        beats(base, gap, BW);
        finish_burst();
    endtask

    // Randomized model state: requests to post, acked addresses, controller burst.
    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic [25:0] req_list[$];
    logic [25:0] posted[$];
    beat_t       exp_q[$];
    int          ack_cyc[$];
    int          cmp_cyc[$];
    int          model_cnt = 0;
    bit          req_on = 0;
    int          ctl_state = 0;
    logic [25:0] ctl_addr = '0;
    int          ctl_beat = 0;
    bit          due = 0;
    int          cyc_n = 0;

    function automatic bit model_idle();
        return req_list.size() == 0 && model_cnt == 0 && ctl_state == 0 && !due && !req_on;
    endfunction

    task automatic cyc(input bit rnd);
        bit    drove;
        beat_t b;
        drove = 0;
        if (!req_on && req_list.size() != 0 && (!rnd || $urandom_range(1, 0) == 1)) req_on = 1;
        vga_sdram_req = req_on;
        if (req_on) vga_sdram_addr = req_list[0];
        arb_grant = rnd ? ($urandom_range(3, 0) != 0) : 1'b1;
        mem_ack = 1'b0;
        mem_rdvalid = 1'b0;
        mem_rdata = '0;
        if (ctl_state == 1 && (!rnd || $urandom_range(2, 0) != 0)) begin
            mem_rdvalid = 1'b1;
            mem_rdata = dword(ctl_addr, ctl_beat);
            b.data = mem_rdata;
            b.last = (ctl_beat == BW - 1);
            exp_q.push_back(b);
            ctl_beat++;
            if (ctl_beat == BW) ctl_state = 0;
            drove = 1;
        end
        #1;
        chk("single_outstanding", 32'(mem_req && ctl_state == 1), 0);
        if (ctl_state == 0 && mem_req && (!rnd || $urandom_range(1, 0) == 1)) begin
            mem_ack = 1'b1;
            if (posted.size() == 0) begin
                chk("issue_without_request", 1, 0);
            end else begin
                ctl_addr = align(posted.pop_front());
                chk("rand_mem_addr", mem_addr, 32'(ctl_addr));
                ctl_state = 1;
                ctl_beat = 0;
            end
        end
        @(negedge clk);
        if (due && exp_q.size() != 0) begin
            b = exp_q.pop_front();
            chk("rand_rdvalid", vga_sdram_rdvalid, 1);
            chk("rand_rdata", vga_sdram_rdata, b.data);
            chk("rand_complete", vga_sdram_complete, 32'(b.last));
            if (b.last) begin
                model_cnt--;
                cmp_cyc.push_back(cyc_n);
            end
        end else begin
            chk("rand_quiet", {vga_sdram_rdvalid, vga_sdram_complete}, 0);
        end
        if (vga_sdram_ack) begin
            chk("ack_room", 32'(model_cnt < 2), 1);
            if (req_list.size() == 0) begin
                chk("spurious_ack", 1, 0);
            end else begin
                posted.push_back(req_list.pop_front());
                model_cnt++;
                ack_cyc.push_back(cyc_n);
            end
            req_on = 0;
        end
        chk("rand_err", err_unexpected, 0);
        due = drove;
        @(posedge clk); #1;
        cyc_n++;
    endtask

    task automatic idle_inputs();
        vga_sdram_req = 1'b0;
        vga_sdram_addr = '0;
        mem_ack = 1'b0;
        mem_rdvalid = 1'b0;
        mem_rdata = '0;
        arb_grant = 1'b1;
    endtask

    typedef struct {
        logic [25:0] addr;
        logic [25:0] exp_addr;
        logic [31:0] base;
        int          gap;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int start;
        bit bad;

        vecs[0] = '{26'h0000123, 26'h0000120, 32'h0000_00A0, 0};
        vecs[1] = '{26'h3FFFFFF, 26'h3FFFFF0, 32'h1111_0000, 2};
        vecs[2] = '{26'h0000010, 26'h0000010, 32'h2222_0010, 1};
        vecs[3] = '{26'h2ABCDEF, 26'h2ABCDE0, 32'hFFFF_FFFE, 0};
        vecs[4] = '{26'h000000F, 26'h0000000, 32'h0BAD_0000, 2};

        #1;
        check_all_zero("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++)
            single_burst(vecs[v].addr, vecs[v].exp_addr, vecs[v].base, vecs[v].gap);

        // Grant withheld while ISSUE waits; then grant lost just before mem_ack.
        arb_grant = 1'b0;
        vga_sdram_req = 1'b1;
        vga_sdram_addr = 26'h1234567;
        @(posedge clk); #1;
        @(negedge clk);
        chk("grant_ack", vga_sdram_ack, 1);
        @(posedge clk); #1;
        vga_sdram_req = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_req) bad = 1;
            @(posedge clk); #1;
        end
        chk("grant_low_no_req", 32'(bad), 0);
        arb_grant = 1'b1;
        @(negedge clk);
        chk("grant_req", mem_req, 1);
        chk("grant_addr", mem_addr, 32'h1234560);
        @(posedge clk); #1;
        arb_grant = 1'b0;
        @(negedge clk);
        chk("grant_drop_req", mem_req, 0);
        @(posedge clk); #1;
        mem_ack = 1'b1;
        @(negedge clk);
        chk("ack_no_grant_req", mem_req, 0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        arb_grant = 1'b1;
        @(negedge clk);
        chk("retry_req", mem_req, 1);
        chk("retry_addr", mem_addr, 32'h1234560);
        chk("retry_busy", vga_busy, 1);
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        beats(32'h5000_0000, 0, BW);
        finish_burst();

        // Three requests held high back-to-back.
        req_list = '{26'h0000400, 26'h0000813, 26'h0000C2F};
        ack_cyc.delete();
        cmp_cyc.delete();
        start = cyc_n;
        for (int i = 0; i < 200 && !model_idle(); i++) cyc(0);
        chk("three_drained", 32'(model_idle()), 1);
        if (ack_cyc.size() == 3 && cmp_cyc.size() == 3) begin
            chk("first_ack_lat", 32'(ack_cyc[0] - start), 1);
            chk("second_ack_lat", 32'(ack_cyc[1] - ack_cyc[0]), 2);
            chk("third_ack_after_complete", 32'(ack_cyc[2] - cmp_cyc[0]), 1);
        end else begin
            chk("three_counts", 32'(ack_cyc.size() * 16 + cmp_cyc.size()), 32'h33);
        end

        // Randomized traffic with grant drops and gapped beats.
        for (int i = 0; i < 40; i++) req_list.push_back(26'($urandom));
        for (int i = 0; i < 4000 && !model_idle(); i++) cyc(1);
        chk("random_drained", 32'(model_idle()), 1);
        idle_inputs();
        @(posedge clk); #1;

        // Stray controller beat while idle.
        mem_rdvalid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_rdvalid = 1'b0;
        mem_rdata = '0;
        @(negedge clk);
        chk("stray_err", err_unexpected, 1);
        chk("stray_no_rdvalid", vga_sdram_rdvalid, 0);
        @(posedge clk); #1;
        single_burst(26'h0000777, 26'h0000770, 32'h7700_0000, 0);
        chk("err_sticky", err_unexpected, 1);

        // Reset asserted after two beats of a burst.
        req_issue(26'h0001234, 26'h0001230);
        beats(32'h3300_0000, 0, 2);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        single_burst(26'h0002345, 26'h0002340, 32'h4400_0000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
